reservation_station_q: RTL and testbench

//  Parametrised, age-ordered, collapsing reservation station feeding one functional unit.

---
 rtl/reservation_station_q_pkg.sv | 27 ++
 rtl/reservation_station_q_if.sv | 48 ++++
 rtl/reservation_station_q_pick.sv | 21 ++
 rtl/reservation_station_q.sv | 141 ++++++++++++++
 tb/tb_reservation_station_q.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/reservation_station_q_pkg.sv
// Shared types and default widths for the age-ordered reservation station.
// Entry and dispatch structs are sized by the package widths below.
package rs_pkg;
  localparam int RS_DEPTH = 4;
  localparam int RS_XLEN  = 32;
  localparam int RS_TAG_W = 4;
  localparam int RS_OP_W  = 6;

  typedef struct packed {
    logic                busy;
    logic [RS_OP_W-1:0]  op;
    logic [RS_TAG_W-1:0] tag;
    logic [RS_TAG_W-1:0] q1;
    logic [RS_TAG_W-1:0] q2;
    logic [RS_XLEN-1:0]  v1;
    logic [RS_XLEN-1:0]  v2;
    logic                v1_rdy;
    logic                v2_rdy;
  } rs_entry_t;

  typedef struct packed {
    logic [RS_OP_W-1:0]  op;
    logic [RS_TAG_W-1:0] tag;
    logic [RS_XLEN-1:0]  v1;
    logic [RS_XLEN-1:0]  v2;
  } rs_disp_t;
endpackage

// File: rtl/reservation_station_q_if.sv
// Issue, CDB, dispatch and status bundle of the reservation station.
// slave = the station, master = the surrounding pipeline / testbench.
interface reservation_station_q_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
);
    logic                       flush_i;
    logic                       issue_valid_i;
    logic                       issue_ready_o;
    logic [OP_W-1:0]            issue_op_i;
    logic [TAG_W-1:0]           issue_tag_i;
    logic [TAG_W-1:0]           issue_q1_i;
    logic [TAG_W-1:0]           issue_q2_i;
    logic [XLEN-1:0]            issue_v1_i;
    logic [XLEN-1:0]            issue_v2_i;
    logic                       issue_v1_rdy_i;
    logic                       issue_v2_rdy_i;
    logic                       cdb_valid_i;
    logic [TAG_W-1:0]           cdb_tag_i;
    logic [XLEN-1:0]            cdb_value_i;
    logic                       disp_valid_o;
    logic                       disp_ready_i;
    logic [OP_W-1:0]            disp_op_o;
    logic [TAG_W-1:0]           disp_tag_o;
    logic [XLEN-1:0]            disp_v1_o;
    logic [XLEN-1:0]            disp_v2_o;
    logic [$clog2(DEPTH+1)-1:0] count_o;
    logic                       full_o;
    logic                       empty_o;

    modport slave (
        input  flush_i, issue_valid_i, issue_op_i, issue_tag_i, issue_q1_i, issue_q2_i,
               issue_v1_i, issue_v2_i, issue_v1_rdy_i, issue_v2_rdy_i,
               cdb_valid_i, cdb_tag_i, cdb_value_i, disp_ready_i,
        output issue_ready_o, disp_valid_o, disp_op_o, disp_tag_o, disp_v1_o, disp_v2_o,
               count_o, full_o, empty_o
    );

    modport master (
        output flush_i, issue_valid_i, issue_op_i, issue_tag_i, issue_q1_i, issue_q2_i,
               issue_v1_i, issue_v2_i, issue_v1_rdy_i, issue_v2_rdy_i,
               cdb_valid_i, cdb_tag_i, cdb_value_i, disp_ready_i,
        input  issue_ready_o, disp_valid_o, disp_op_o, disp_tag_o, disp_v1_o, disp_v2_o,
               count_o, full_o, empty_o
    );
endinterface

// File: rtl/reservation_station_q_pick.sv
// Lowest-index (oldest) ready selector: one-hot grant, binary index, any flag.
module rs_oldest_ready_pick #(
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);
    assign any = |req;
    assign gnt = req & (~req + DEPTH'(1));

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (req[k]) idx = IW'(k);
        end
    end
endmodule

// File: rtl/reservation_station_q.sv
// Collapsing, age-ordered reservation station with CDB snoop and a registered dispatch stage.
// Optional RS_CDB_BYPASS_EN: an entry woken by the current CDB may be selected in the same cycle.
module reservation_station_q
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int XLEN  = RS_XLEN,
    parameter int TAG_W = RS_TAG_W,
    parameter int OP_W  = RS_OP_W
) (
    input logic                    clk,
    input logic                    rst,
    reservation_station_q_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    // Entry layout is fixed by the package structs, so the widths must agree.
    if (XLEN != RS_XLEN || TAG_W != RS_TAG_W || OP_W != RS_OP_W || DEPTH < 2) begin : g_bad_cfg
        $error("reservation_station_q: width parameters must match rs_pkg and DEPTH >= 2");
    end

    rs_entry_t        ent [DEPTH];
    rs_entry_t        cap [DEPTH];
    rs_entry_t        nxt [DEPTH];
    rs_entry_t        new_ent;
    rs_entry_t        sel_ent;
    rs_disp_t         disp;
    logic             disp_valid;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] hit1, hit2, elig, gnt;
    logic [IW-1:0]    sel;
    logic             any, load, issue_ready, issue_fire;

    assign issue_ready = int'(count) < DEPTH;
    assign issue_fire  = bus.issue_valid_i && issue_ready;
    assign load        = any && (!disp_valid || bus.disp_ready_i);

    // Per-entry CDB match; cap[] is the entry as it looks after this cycle's snoop.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            hit1[k] = ent[k].busy && !ent[k].v1_rdy && bus.cdb_valid_i && (ent[k].q1 == bus.cdb_tag_i);
            hit2[k] = ent[k].busy && !ent[k].v2_rdy && bus.cdb_valid_i && (ent[k].q2 == bus.cdb_tag_i);
            cap[k]  = ent[k];
            if (hit1[k]) begin
                cap[k].v1     = bus.cdb_value_i;
                cap[k].v1_rdy = 1'b1;
            end
            if (hit2[k]) begin
                cap[k].v2     = bus.cdb_value_i;
                cap[k].v2_rdy = 1'b1;
            end
`ifdef RS_CDB_BYPASS_EN
            elig[k] = cap[k].busy && cap[k].v1_rdy && cap[k].v2_rdy;
`else
            elig[k] = ent[k].busy && ent[k].v1_rdy && ent[k].v2_rdy;
`endif
        end
    end

    rs_oldest_ready_pick #(.DEPTH(DEPTH), .IW(IW)) u_pick (
        .req (elig),
        .gnt (gnt),
        .idx (sel),
        .any (any)
    );

    // cap[] carries any bypassed CDB value; without bypass it equals ent[] for eligible entries.
    always_comb begin
        sel_ent = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (gnt[k]) sel_ent = sel_ent | cap[k];
        end
    end

    always_comb begin
        new_ent        = '0;
        new_ent.busy   = 1'b1;
        new_ent.op     = bus.issue_op_i;
        new_ent.tag    = bus.issue_tag_i;
        new_ent.q1     = bus.issue_q1_i;
        new_ent.q2     = bus.issue_q2_i;
        new_ent.v1     = bus.issue_v1_i;
        new_ent.v2     = bus.issue_v2_i;
        new_ent.v1_rdy = bus.issue_v1_rdy_i;
        new_ent.v2_rdy = bus.issue_v2_rdy_i;
        if (!bus.issue_v1_rdy_i && bus.cdb_valid_i && bus.issue_q1_i == bus.cdb_tag_i) begin
            new_ent.v1     = bus.cdb_value_i;
            new_ent.v1_rdy = 1'b1;
        end
        if (!bus.issue_v2_rdy_i && bus.cdb_valid_i && bus.issue_q2_i == bus.cdb_tag_i) begin
            new_ent.v2     = bus.cdb_value_i;
            new_ent.v2_rdy = 1'b1;
        end
    end

    // Collapse above the leaving entry, then append the new op at the tail.
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        rs_entry_t above;
        if (k < DEPTH - 1) begin : g_mid
            assign above = cap[k+1];
        end else begin : g_top
            assign above = '0;
        end
        always_comb begin
            nxt[k] = (load && k >= int'(sel)) ? above : cap[k];
            if (issue_fire && k == int'(count) - int'(load)) nxt[k] = new_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
            count      <= '0;
            disp_valid <= 1'b0;
            if (rst) disp <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) ent[k] <= nxt[k];
            count <= count + CW'(issue_fire) - CW'(load);
            if (load) begin
                disp_valid <= 1'b1;
                disp.op    <= sel_ent.op;
                disp.tag   <= sel_ent.tag;
                disp.v1    <= sel_ent.v1;
                disp.v2    <= sel_ent.v2;
            end else if (bus.disp_ready_i) begin
                disp_valid <= 1'b0;
            end
        end
    end

    assign bus.issue_ready_o = issue_ready;
    assign bus.disp_valid_o  = disp_valid;
    assign bus.disp_op_o     = disp.op;
    assign bus.disp_tag_o    = disp.tag;
    assign bus.disp_v1_o     = disp.v1;
    assign bus.disp_v2_o     = disp.v2;
    assign bus.count_o       = count;
    assign bus.full_o        = int'(count) == DEPTH;
    assign bus.empty_o       = count == '0;
endmodule

// File: tb/tb_reservation_station_q.sv
// Directed self-checking bench for reservation_station_q (DEPTH=4, XLEN=32).
module tb_reservation_station_q;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reservation_station_q_if #(.DEPTH(4), .XLEN(32), .TAG_W(4), .OP_W(6)) bus ();

    reservation_station_q #(.DEPTH(4), .XLEN(32), .TAG_W(4), .OP_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_i        = 1'b0;
        bus.issue_valid_i  = 1'b0;
        bus.issue_op_i     = '0;
        bus.issue_tag_i    = '0;
        bus.issue_q1_i     = '0;
        bus.issue_q2_i     = '0;
        bus.issue_v1_i     = '0;
        bus.issue_v2_i     = '0;
        bus.issue_v1_rdy_i = 1'b0;
        bus.issue_v2_rdy_i = 1'b0;
        bus.cdb_valid_i    = 1'b0;
        bus.cdb_tag_i      = '0;
        bus.cdb_value_i    = '0;
        bus.disp_ready_i   = 1'b1;
    endtask

    task automatic put(input logic [3:0] tag, input logic [3:0] q1, input logic [3:0] q2,
                       input logic [31:0] v1, input logic [31:0] v2, input logic r1, input logic r2);
        bus.issue_valid_i  = 1'b1;
        bus.issue_op_i     = 6'(tag + 4'd8);
        bus.issue_tag_i    = tag;
        bus.issue_q1_i     = q1;
        bus.issue_q2_i     = q2;
        bus.issue_v1_i     = v1;
        bus.issue_v2_i     = v2;
        bus.issue_v1_rdy_i = r1;
        bus.issue_v2_rdy_i = r2;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.disp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_disp_valid got=%0b exp=0", bus.disp_valid_o); end
        checks++; if (bus.count_o !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.count_o); end
        checks++; if ({bus.full_o, bus.empty_o, bus.issue_ready_o} !== 3'b011) begin failures++; $display("FAIL rst_flags got=%b exp=011", {bus.full_o, bus.empty_o, bus.issue_ready_o}); end
        checks++; if ({bus.disp_op_o, bus.disp_tag_o, bus.disp_v1_o, bus.disp_v2_o} !== 74'd0) begin failures++; $display("FAIL rst_disp_data got=%0h exp=0", {bus.disp_op_o, bus.disp_tag_o, bus.disp_v1_o, bus.disp_v2_o}); end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        put(4'd3, 4'd0, 4'd0, 32'd5, 32'd7, 1'b1, 1'b1);
        tick();
        idle();
        checks++; if (bus.disp_valid_o !== 1'b0 || bus.count_o !== 3'd1) begin failures++; $display("FAIL lat_n1 got=v%0b c%0d exp=v0 c1", bus.disp_valid_o, bus.count_o); end
        tick();
        checks++; if (bus.disp_valid_o !== 1'b1 || bus.disp_tag_o !== 4'd3 || bus.disp_op_o !== 6'd11) begin failures++; $display("FAIL lat_n2 got=v%0b t%0d o%0d exp=v1 t3 o11", bus.disp_valid_o, bus.disp_tag_o, bus.disp_op_o); end
        checks++; if (bus.disp_v1_o !== 32'd5 || bus.disp_v2_o !== 32'd7 || bus.count_o !== 3'd0) begin failures++; $display("FAIL lat_data got=%0d/%0d c%0d exp=5/7 c0", bus.disp_v1_o, bus.disp_v2_o, bus.count_o); end
        tick();
        checks++; if (bus.disp_valid_o !== 1'b0 || bus.empty_o !== 1'b1) begin failures++; $display("FAIL lat_drain got=v%0b e%0b exp=v0 e1", bus.disp_valid_o, bus.empty_o); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            put(4'(i), 4'd9, 4'd9, 32'd0, 32'd0, 1'b0, 1'b0);
            tick();
        end
        checks++; if (bus.count_o !== 3'd4 || bus.full_o !== 1'b1 || bus.issue_ready_o !== 1'b0) begin failures++; $display("FAIL full_flags got=c%0d f%0b r%0b exp=c4 f1 r0", bus.count_o, bus.full_o, bus.issue_ready_o); end
        put(4'd5, 4'd0, 4'd0, 32'd1, 32'd1, 1'b1, 1'b1);
        tick();
        idle();
        checks++; if (bus.count_o !== 3'd4 || bus.disp_valid_o !== 1'b0) begin failures++; $display("FAIL full_drop got=c%0d v%0b exp=c4 v0", bus.count_o, bus.disp_valid_o); end
        bus.flush_i = 1'b1;
        tick();
        idle();
        checks++; if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1) begin failures++; $display("FAIL full_flush got=c%0d e%0b exp=c0 e1", bus.count_o, bus.empty_o); end
    endtask

    task automatic test_cdb_snoop();
        int waited;
        put(4'd10, 4'd1, 4'd0, 32'd0, 32'h100, 1'b0, 1'b1); tick();
        put(4'd11, 4'd2, 4'd0, 32'd0, 32'h101, 1'b0, 1'b1); tick();
        put(4'd12, 4'd1, 4'd0, 32'd0, 32'h102, 1'b0, 1'b1); tick();
        idle();
        bus.cdb_valid_i = 1'b1; bus.cdb_tag_i = 4'd1; bus.cdb_value_i = 32'hAA;
        tick();
        bus.cdb_valid_i = 1'b0;
`ifndef RS_CDB_BYPASS_EN
        checks++; if (bus.disp_valid_o !== 1'b0 || bus.count_o !== 3'd3) begin failures++; $display("FAIL cdb_nobypass got=v%0b c%0d exp=v0 c3", bus.disp_valid_o, bus.count_o); end
`else
        checks++; if (bus.disp_valid_o !== 1'b1 || bus.count_o !== 3'd2) begin failures++; $display("FAIL cdb_bypass got=v%0b c%0d exp=v1 c2", bus.disp_valid_o, bus.count_o); end
`endif
        waited = 0;
        while (bus.disp_valid_o !== 1'b1 && waited < 5) begin tick(); waited++; end
        checks++; if (bus.disp_valid_o !== 1'b1 || bus.disp_tag_o !== 4'd10 || bus.disp_v1_o !== 32'hAA || bus.disp_v2_o !== 32'h100) begin failures++; $display("FAIL cdb_first got=v%0b t%0d v1=%0h v2=%0h exp=v1 t10 aa 100", bus.disp_valid_o, bus.disp_tag_o, bus.disp_v1_o, bus.disp_v2_o); end
        tick();
        checks++; if (bus.disp_valid_o !== 1'b1 || bus.disp_tag_o !== 4'd12 || bus.disp_v1_o !== 32'hAA || bus.disp_v2_o !== 32'h102) begin failures++; $display("FAIL cdb_second got=v%0b t%0d v1=%0h v2=%0h exp=v1 t12 aa 102", bus.disp_valid_o, bus.disp_tag_o, bus.disp_v1_o, bus.disp_v2_o); end
        tick();
        checks++; if (bus.disp_valid_o !== 1'b0 || bus.count_o !== 3'd1) begin failures++; $display("FAIL cdb_left got=v%0b c%0d exp=v0 c1", bus.disp_valid_o, bus.count_o); end
        bus.flush_i = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_issue_collision();
        put(4'd5, 4'd6, 4'd0, 32'd0, 32'h22, 1'b0, 1'b1);
        bus.cdb_valid_i = 1'b1; bus.cdb_tag_i = 4'd6; bus.cdb_value_i = 32'h11;
        tick();
        idle();
        checks++; if (bus.count_o !== 3'd1 || bus.disp_valid_o !== 1'b0) begin failures++; $display("FAIL coll_n1 got=c%0d v%0b exp=c1 v0", bus.count_o, bus.disp_valid_o); end
        tick();
        checks++; if (bus.disp_valid_o !== 1'b1 || bus.disp_tag_o !== 4'd5 || bus.disp_v1_o !== 32'h11 || bus.disp_v2_o !== 32'h22) begin failures++; $display("FAIL coll_disp got=v%0b t%0d v1=%0h v2=%0h exp=v1 t5 11 22", bus.disp_valid_o, bus.disp_tag_o, bus.disp_v1_o, bus.disp_v2_o); end
        tick();
    endtask

    task automatic test_backpressure();
        bus.disp_ready_i = 1'b0;
        put(4'd7, 4'd0, 4'd0, 32'd1, 32'd2, 1'b1, 1'b1); tick();
        put(4'd8, 4'd0, 4'd0, 32'd3, 32'd4, 1'b1, 1'b1); tick();
        bus.issue_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.disp_valid_o !== 1'b1 || bus.disp_tag_o !== 4'd7 || bus.disp_v1_o !== 32'd1 || bus.disp_v2_o !== 32'd2 || bus.count_o !== 3'd1) begin failures++; $display("FAIL bp_hold%0d got=v%0b t%0d v1=%0d v2=%0d c%0d exp=v1 t7 1 2 c1", i, bus.disp_valid_o, bus.disp_tag_o, bus.disp_v1_o, bus.disp_v2_o, bus.count_o); end
            tick();
        end
        bus.disp_ready_i = 1'b1;
        tick();
        checks++; if (bus.disp_valid_o !== 1'b1 || bus.disp_tag_o !== 4'd8 || bus.disp_v1_o !== 32'd3 || bus.count_o !== 3'd0) begin failures++; $display("FAIL bp_release got=v%0b t%0d v1=%0d c%0d exp=v1 t8 3 c0", bus.disp_valid_o, bus.disp_tag_o, bus.disp_v1_o, bus.count_o); end
        tick();
        checks++; if (bus.disp_valid_o !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", bus.disp_valid_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            put(4'(i), 4'd0, 4'd0, 32'(i * 16), 32'(i), 1'b1, 1'b1);
            tick();
            if (i >= 2) begin
                checks++; if (bus.disp_valid_o !== 1'b1 || bus.disp_tag_o !== 4'(i - 1) || bus.disp_v1_o !== 32'((i - 1) * 16)) begin failures++; $display("FAIL b2b_%0d got=v%0b t%0d v1=%0h exp=v1 t%0d", i - 1, bus.disp_valid_o, bus.disp_tag_o, bus.disp_v1_o, i - 1); end
            end
        end
        idle();
        tick();
        checks++; if (bus.disp_valid_o !== 1'b1 || bus.disp_tag_o !== 4'd3 || bus.count_o !== 3'd0) begin failures++; $display("FAIL b2b_3 got=v%0b t%0d c%0d exp=v1 t3 c0", bus.disp_valid_o, bus.disp_tag_o, bus.count_o); end
        tick();
    endtask

    task automatic test_flush();
        bus.disp_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            put(4'(i), 4'd0, 4'd0, 32'd9, 32'd9, 1'b1, 1'b1);
            tick();
        end
        checks++; if (bus.count_o !== 3'd3 || bus.disp_valid_o !== 1'b1) begin failures++; $display("FAIL flush_pre got=c%0d v%0b exp=c3 v1", bus.count_o, bus.disp_valid_o); end
        bus.flush_i = 1'b1;
        put(4'd14, 4'd0, 4'd0, 32'd1, 32'd1, 1'b1, 1'b1);
        tick();
        idle();
        checks++; if (bus.count_o !== 3'd0 || bus.disp_valid_o !== 1'b0 || bus.empty_o !== 1'b1) begin failures++; $display("FAIL flush_now got=c%0d v%0b e%0b exp=c0 v0 e1", bus.count_o, bus.disp_valid_o, bus.empty_o); end
        tick();
        tick();
        checks++; if (bus.count_o !== 3'd0 || bus.disp_valid_o !== 1'b0) begin failures++; $display("FAIL flush_after got=c%0d v%0b exp=c0 v0", bus.count_o, bus.disp_valid_o); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full();
        test_cdb_snoop();
        test_issue_collision();
        test_backpressure();
        test_back_to_back();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
